// File: rtl/photonic_switch_top.sv
`timescale 1ns / 1ps
// Photonic switch PWM generator: 200 MHz prescaler strobes, synchronized A/B pulse-edge
// counters per 1 us frame, and an SR-style PWM output driven by threshold matches.
module photonic_switch_top (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clkA,
    input  logic       clkB,
    input  logic [6:0] A_val,
    input  logic [6:0] B_val,
    output logic       PWMset,
    output logic       PWMreset,
    output logic       signal,
    output logic [6:0] cA,
    output logic [6:0] cB,
    output logic       temp,
    output logic [4:0] c1,
    output logic [4:0] c2,
    output logic       en_8MHz,
    output logic       en_1MHz
);

    localparam logic [4:0] C1Max  = 5'd24;
    localparam logic [4:0] C2Max  = 5'd7;
    localparam logic [6:0] CntSat = 7'd127;

    logic [4:0] c1_q, c1_d, c2_q, c2_d;
    logic       temp_q, temp_d;
    logic       a_meta_q, a_sync_q, a_hist_q;
    logic       b_meta_q, b_sync_q, b_hist_q;
    logic       rise_a, rise_b;
    logic [6:0] ca_q, ca_d, cb_q, cb_d;
    logic       ca_new, cb_new;
    logic       set_q, set_d, rst_q, rst_d;
    logic       sig_q, sig_d;

    always_comb begin
        en_8MHz = en & (c1_q == C1Max);
        en_1MHz = en_8MHz & (c2_q == C2Max);

        c1_d = c1_q;
        if (en) begin
            c1_d = (c1_q == C1Max) ? 5'd0 : c1_q + 5'd1;
        end

        c2_d   = c2_q;
        temp_d = temp_q;
        if (en_8MHz) begin
            c2_d   = (c2_q == C2Max) ? 5'd0 : c2_q + 5'd1;
            temp_d = ~temp_q;
        end
    end

    assign rise_a = a_sync_q & ~a_hist_q;
    assign rise_b = b_sync_q & ~b_hist_q;

    // Frame start reloads the counters and discards any edge detected in the same cycle;
    // the reload itself counts as a new value so a zero threshold fires at frame start.
    always_comb begin
        ca_d   = ca_q;
        cb_d   = cb_q;
        ca_new = 1'b0;
        cb_new = 1'b0;
        if (en_1MHz) begin
            ca_d   = 7'd0;
            cb_d   = 7'd0;
            ca_new = 1'b1;
            cb_new = 1'b1;
        end else if (en) begin
            if (rise_a && (ca_q != CntSat)) begin
                ca_d   = ca_q + 7'd1;
                ca_new = 1'b1;
            end
            if (rise_b && (cb_q != CntSat)) begin
                cb_d   = cb_q + 7'd1;
                cb_new = 1'b1;
            end
        end

        set_d = ca_new & (ca_d == A_val);
        rst_d = cb_new & (cb_d == B_val);

        sig_d = sig_q;
        if (rst_q) begin
            sig_d = 1'b0;
        end else if (set_q) begin
            sig_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c1_q     <= 5'd0;
            c2_q     <= 5'd0;
            temp_q   <= 1'b0;
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            a_hist_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
            b_hist_q <= 1'b0;
            ca_q     <= 7'd0;
            cb_q     <= 7'd0;
            set_q    <= 1'b0;
            rst_q    <= 1'b0;
            sig_q    <= 1'b0;
        end else begin
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            temp_q   <= temp_d;
            a_meta_q <= clkA;
            a_sync_q <= a_meta_q;
            a_hist_q <= a_sync_q;
            b_meta_q <= clkB;
            b_sync_q <= b_meta_q;
            b_hist_q <= b_sync_q;
            ca_q     <= ca_d;
            cb_q     <= cb_d;
            set_q    <= set_d;
            rst_q    <= rst_d;
            sig_q    <= sig_d;
        end
    end

    assign c1       = c1_q;
    assign c2       = c2_q;
    assign temp     = temp_q;
    assign cA       = ca_q;
    assign cB       = cb_q;
    assign PWMset   = set_q;
    assign PWMreset = rst_q;
    assign signal   = sig_q;

endmodule

// File: tb/tb_photonic_switch_top.sv
`timescale 1ns / 1ps
// Bench for photonic_switch_top: cycle model feeds a scoreboard of expected output vectors,
// plus targeted checks on strobe periods, frame behaviour, enable gaps and resets.
module tb_photonic_switch_top;

    logic       clk, reset, en, clkA, clkB;
    logic [6:0] A_val, B_val;
    logic       PWMset, PWMreset, signal, temp, en_8MHz, en_1MHz;
    logic [6:0] cA, cB;
    logic [4:0] c1, c2;

    int  n_vec = 0;
    int  n_bad = 0;
    bit  sb_on = 0;
    logic [29:0] exp_q[$];

    photonic_switch_top dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clkA     (clkA),
        .clkB     (clkB),
        .A_val    (A_val),
        .B_val    (B_val),
        .PWMset   (PWMset),
        .PWMreset (PWMreset),
        .signal   (signal),
        .cA       (cA),
        .cB       (cB),
        .temp     (temp),
        .c1       (c1),
        .c2       (c2),
        .en_8MHz  (en_8MHz),
        .en_1MHz  (en_1MHz)
    );

    initial begin
        clk = 1'b0;
        forever #2.5 clk = ~clk;
    end

    // Offsets chosen so pulse-source edges never coincide with a clk rising edge.
    initial begin
        clkA = 1'b0;
        #1.1;
        forever #6.25 clkA = ~clkA;
    end

    initial begin
        clkB = 1'b0;
        #0.31;
        forever #6.175 clkB = ~clkB;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit m_ma, m_sa, m_ha, m_mb, m_sb, m_hb, m_temp, m_set, m_rst, m_sig;
    int m_c1, m_c2, m_ca, m_cb;

    task automatic model_step();
        bit e8, e1, ra, rb, na, nb;
        if (reset) begin
            {m_ma, m_sa, m_ha, m_mb, m_sb, m_hb} = '0;
            {m_temp, m_set, m_rst, m_sig} = '0;
            m_c1 = 0; m_c2 = 0; m_ca = 0; m_cb = 0;
        end else begin
            e8 = en && (m_c1 == 24);
            e1 = e8 && (m_c2 == 7);
            ra = m_sa && !m_ha;
            rb = m_sb && !m_hb;
            if (m_rst) m_sig = 0;
            else if (m_set) m_sig = 1;
            na = 0;
            nb = 0;
            if (e1) begin
                m_ca = 0; m_cb = 0; na = 1; nb = 1;
            end else if (en) begin
                if (ra && m_ca < 127) begin m_ca++; na = 1; end
                if (rb && m_cb < 127) begin m_cb++; nb = 1; end
            end
            m_set = na && (m_ca == int'(A_val));
            m_rst = nb && (m_cb == int'(B_val));
            if (en) m_c1 = (m_c1 + 1) % 25;
            if (e8) begin
                m_c2   = (m_c2 + 1) % 8;
                m_temp = !m_temp;
            end
            m_ha = m_sa; m_sa = m_ma; m_ma = clkA;
            m_hb = m_sb; m_sb = m_mb; m_mb = clkB;
        end
    endtask

    function automatic logic [29:0] model_vec();
        logic e8, e1;
        e8 = en && (m_c1 == 24);
        e1 = e8 && (m_c2 == 7);
        return {m_set, m_rst, m_sig, 7'(m_ca), 7'(m_cb), m_temp, 5'(m_c1), 5'(m_c2), e8, e1};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {PWMset, PWMreset, signal, cA, cB, temp, c1, c2, en_8MHz, en_1MHz};
    endfunction

    // Inputs change 1 ns after the edge, so by +2 ns the model sees this cycle's inputs.
    always @(posedge clk) begin
        model_step();
        #2;
        if (sb_on) exp_q.push_back(model_vec());
    end

    always @(negedge clk) begin
        logic [29:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("cycle@%0t", $time), {2'b00, dut_vec()}, {2'b00, e});
        end
    end

    function automatic logic probe(input int which);
        case (which)
            0:       return en_8MHz;
            1:       return en_1MHz;
            default: return temp;
        endcase
    endfunction

    task automatic count_until(input int which, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!probe(which) && n < 400);
        if (!probe(which)) check_eq($sformatf("timeout_%0d", which), {31'd0, probe(which)}, 1);
    endtask

    task automatic count_temp(output int n);
        logic t0;
        t0 = temp;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (temp == t0 && n < 400);
    endtask

    // Observe one frame: the 199 cycles following a detected frame-start strobe.
    task automatic frame(output int nset, output int nrst, output int nsig, output int fset);
        int n;
        count_until(1, n);
        nset = 0; nrst = 0; nsig = 0; fset = 0;
        for (int i = 1; i <= 199; i++) begin
            @(negedge clk);
            if (i == 1) fset = int'(PWMset);
            nset += int'(PWMset);
            nrst += int'(PWMreset);
            nsig += int'(signal);
        end
    endtask

    task automatic step_in();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, nset, nrst, nsig, fset, strobes;
        reset = 1'b1;
        en    = 1'b0;
        A_val = 7'd2;
        B_val = 7'd15;
        step_in();
        sb_on = 1;
        step_in();
        @(negedge clk);
        check_eq("reset_state", {2'b00, dut_vec()}, 32'd0);

        // Prescaler
        step_in();
        reset = 1'b0;
        en    = 1'b1;
        count_until(0, n);
        check_eq("first_e8", n, 25);
        count_until(0, n);
        check_eq("e8_period", n, 25);
        count_until(1, n);
        count_until(1, n);
        check_eq("e1_period", n, 200);
        count_temp(n);
        count_temp(n);
        check_eq("temp_half_period", n, 25);

        // PWM with A_val=2, B_val=15
        frame(nset, nrst, nsig, fset);
        frame(nset, nrst, nsig, fset);
        check_eq("pwm_set_count", nset, 1);
        check_eq("pwm_reset_count", nrst, 1);
        check_eq("pwm_high_width_ok", {31'd0, (nsig >= 25 && nsig <= 40)}, 1);

        // Enable gap mid-frame
        count_until(1, n);
        repeat (20) step_in();
        en = 1'b0;
        strobes = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            strobes += int'(en_8MHz | en_1MHz | PWMset | PWMreset);
        end
        check_eq("gap_strobes", strobes, 0);
        step_in();
        en = 1'b1;

        // Mid-run reset pulse
        repeat (30) step_in();
        reset = 1'b1;
        step_in();
        @(negedge clk);
        check_eq("midrun_reset", {2'b00, dut_vec()}, 32'd0);
        step_in();
        reset = 1'b0;
        count_until(0, n);
        check_eq("e8_after_reset", n, 25);

        // B_val beyond reachable count: no PWMreset
        step_in();
        B_val = 7'd100;
        frame(nset, nrst, nsig, fset);
        frame(nset, nrst, nsig, fset);
        check_eq("bval100_no_reset", nrst, 0);
        check_eq("bval100_set", nset, 1);

        // A_val=B_val=0: both fire at frame start, reset dominates
        step_in();
        A_val = 7'd0;
        B_val = 7'd0;
        frame(nset, nrst, nsig, fset);
        frame(nset, nrst, nsig, fset);
        check_eq("aval0_set_at_start", fset, 1);
        check_eq("aval0_set_count", nset, 1);
        check_eq("equal_vals_signal_low", nsig, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
